bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Consumer end of the keypad encoder interface in the microwave controller. Takes the encoder's BCD digit `D`, key strobe `load`, and muxed `pgt_1Hz` (key pulse in entry mode, 1 Hz tick in cook mode). It shifts keyed digits into a four-digit MM:SS register and counts that register down to 00:00. It drives the display digits and the end-of-cook indication.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits held; only 4 (MM:SS) is supported.
- `SEC_WRAP`, 59: seconds value loaded on a minute borrow.

Ports:
- `clk`  in  1: single system clock; all logic on its rising edge.
- `clear_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: mode select shared with the encoder; 0 = entry, 1 = count.
- `D`  in  4: BCD digit from the encoder; values 10–15 are invalid.
- `load`  in  1: high while a key decodes to a valid digit.
- `pgt_1Hz`  in  1: key pulse when `en`=0; 1 Hz square wave when `en`=1.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each: BCD display digits.
- `zero`  out  1: high when all four digits are 0.
- `done`  out  1: one-cycle pulse when a countdown reaches 00:00.
- `state`  out  2: current FSM state, for the display and buzzer logic.

## Operation
- Edge detect: `pgt_prev` holds `pgt_1Hz` from the previous cycle. `tick = pgt_1Hz & ~pgt_prev`.
- FSM states are ENTRY, COUNT and DONE. Reset state is ENTRY.
- ENTRY:
  - On `tick & load & ~en & D<=9`, shift left one digit: `min_tens<=min_ones`, `min_ones<=sec_tens`, `sec_tens<=sec_ones`, `sec_ones<=D`. The old `min_tens` is discarded.
  - A tick with D>9 or with `load`=0 changes nothing.
  - If `en`=1 and `zero`=0, go to COUNT. If `en`=1 and `zero`=1, stay in ENTRY.
- COUNT:
  - On `tick`, decrement MM:SS in BCD.
  - When `sec_ones`=0 it borrows from `sec_tens`.
  - When seconds = 00 and minutes ≠ 00, seconds load `SEC_WRAP` and minutes decrement; `min_ones`=0 borrows from `min_tens`.
  - Entered `sec_tens` values above 5 are legal and decrement normally, e.g. 0:99 → 0:98.
  - When the decrement produces 00:00, go to DONE and pulse `done`.
  - If `en`=0 with no tick, go to ENTRY with digits held (pause).
- DONE:
  - Digits stay at 00:00.
  - The first valid entry (`tick & load & ~en & D<=9`) clears all digits, loads `D` into `sec_ones`, and goes to ENTRY.
  - `en`=1 keeps the block in DONE.
- Simultaneous events:
  - In COUNT, if `en` drops on the same cycle as a tick, the decrement is applied and the next state is ENTRY.
  - In ENTRY, if `en` rises on a tick cycle, no shift occurs and no decrement occurs; counting starts with the next tick.
- `clear_n`=0 at any time, including mid-countdown, takes effect at the next edge: all digits 0, state ENTRY, `done`=0, `pgt_prev`=0.

## Timing
- Reset values: all digits 0, `zero`=1, `done`=0, `state`=ENTRY.
- Shift and decrement take effect at the same `clk` edge that first samples `pgt_1Hz` high. Outputs are registered and visible after that edge.
- `zero` is combinational from the digit registers. `done` is registered and high for exactly one cycle.
- A level `pgt_1Hz` held high for many cycles yields exactly one tick.
- Inputs are assumed synchronous to `clk` unless the macro below is defined.

## Configuration
- `BCD_TIMER_SYNC_EN`:
  - Defined: `pgt_1Hz`, `load` and `D` pass through a two-flop synchronizer before edge detection. This adds 2 cycles of latency from input edge to register update.
  - Undefined: inputs go straight to edge detection, with 0 added latency.

## Structure
- `bcd_timer_pkg` holds:
  - the state enum (ENTRY=0, COUNT=1, DONE=2);
  - `BCD_MAX`=9;
  - `SEC_WRAP_TENS`=5 and `SEC_WRAP_ONES`=9.
- Sub-module `bcd_digit_dec`: one digit, combinational. Inputs: digit in, borrow in, wrap value. Outputs: digit out, borrow out. Four instances are chained for the MM:SS decrement.

## Test plan
- Entry: reset, `en`=0, key ticks with D=1,3,0 → display 01:30 with `state`=ENTRY. A tick with D=12 leaves 01:30.
- Borrow: from 01:00, set `en`=1 and apply one tick → 00:59. Apply 59 more ticks → 00:00, `done` high for exactly 1 cycle, `state`=DONE.
- Non-standard seconds: enter 0,0,9,9 then count one tick → 00:98.
- Pause: from 00:45 in COUNT, drop `en` → ENTRY with 00:45 held. Raise `en` and apply one tick → 00:44.
- Edge handling: hold `pgt_1Hz` high for 20 cycles in COUNT from 00:10 → exactly one decrement, giving 00:09. Start from 00:00 with `en`=1 → stays in ENTRY with no `done`.
- Reset mid-count: assert `clear_n`=0 for one cycle at 02:17 in COUNT → next cycle shows 00:00, `state`=ENTRY, `done`=0.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] SEC_WRAP_TENS = 4'd5;
  localparam logic [3:0] SEC_WRAP_ONES = 4'd9;

  // Value a digit takes when it borrows: the seconds pair reloads from sec_wrap,
  // minute digits wrap to 9.
  function automatic logic [3:0] wrap_digit(input int idx, input int sec_wrap);
    case (idx)
      0:       return 4'(sec_wrap % 10);
      1:       return 4'(sec_wrap / 10);
      default: return BCD_MAX;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow, wrapping on 0.
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_borrow,
  input  logic [3:0] i_wrap,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_borrow) begin
      if (i_digit == 4'd0) begin
        o_digit  = i_wrap;
        o_borrow = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Keypad-loaded MM:SS BCD countdown timer with ENTRY/COUNT/DONE FSM.
// Define BCD_TIMER_SYNC_EN to pass pgt_1Hz, load and D through a two-flop synchronizer.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SEC_WRAP = int'(SEC_WRAP_TENS) * 10 + int'(SEC_WRAP_ONES)
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       en,
  input  logic [3:0] D,
  input  logic       load,
  input  logic       pgt_1Hz,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       done,
  output logic [1:0] state
);

  logic                   w_pgt;
  logic                   w_load;
  logic [3:0]             w_d;
  logic                   r_pgt_prev;
  logic                   r_done;
  state_t                 r_state;
  logic [DIGITS-1:0][3:0] r_dig;
  logic [DIGITS-1:0][3:0] w_dec;
  logic [DIGITS:0]        w_borrow;
  logic                   w_tick;
  logic                   w_key;
  logic                   w_zero;

`ifdef BCD_TIMER_SYNC_EN
  logic [1:0]      r_pgt_sync;
  logic [1:0]      r_load_sync;
  logic [1:0][3:0] r_d_sync;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_pgt_sync  <= '0;
      r_load_sync <= '0;
      r_d_sync    <= '0;
    end else begin
      r_pgt_sync  <= {r_pgt_sync[0], pgt_1Hz};
      r_load_sync <= {r_load_sync[0], load};
      r_d_sync    <= {r_d_sync[0], D};
    end
  end

  assign w_pgt  = r_pgt_sync[1];
  assign w_load = r_load_sync[1];
  assign w_d    = r_d_sync[1];
`else
  assign w_pgt  = pgt_1Hz;
  assign w_load = load;
  assign w_d    = D;
`endif

  assign w_tick = w_pgt & ~r_pgt_prev;
  assign w_key  = w_tick & w_load & ~en & (w_d <= BCD_MAX);
  assign w_zero = (r_dig == '0);

  // Ripple-borrow chain, sec_ones first; a borrow out of the top digit means 00:00.
  assign w_borrow[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .i_digit (r_dig[g]),
      .i_borrow(w_borrow[g]),
      .i_wrap  (wrap_digit(g, SEC_WRAP)),
      .o_digit (w_dec[g]),
      .o_borrow(w_borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_pgt_prev <= 1'b0;
      r_done     <= 1'b0;
      r_state    <= ENTRY;
      r_dig      <= '0;
    end else begin
      r_pgt_prev <= w_pgt;
      r_done     <= 1'b0;
      case (r_state)
        ENTRY: begin
          if (en) begin
            if (!w_zero) r_state <= COUNT;
          end else if (w_key) begin
            r_dig <= {r_dig[DIGITS-2:0], w_d};
          end
        end
        COUNT: begin
          if (w_tick && !w_borrow[DIGITS]) begin
            r_dig <= w_dec;
            if (w_dec == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (!en) begin
              r_state <= ENTRY;
            end
          end else if (!en) begin
            r_state <= ENTRY;
          end
        end
        DONE: begin
          if (w_key) begin
            r_dig   <= {{(DIGITS-1){4'd0}}, w_d};
            r_state <= ENTRY;
          end
        end
        default: r_state <= ENTRY;
      endcase
    end
  end

  assign min_tens = r_dig[3];
  assign min_ones = r_dig[2];
  assign sec_tens = r_dig[1];
  assign sec_ones = r_dig[0];
  assign zero     = w_zero;
  assign done     = r_done;
  assign state    = r_state;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_bcd_countdown_timer;

  localparam logic [1:0] S_ENTRY = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic       clk;
  logic       clear_n;
  logic       en;
  logic [3:0] D;
  logic       load;
  logic       pgt_1Hz;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, done;
  logic [1:0] state;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] dig;
    logic        dn;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  bcd_countdown_timer dut (
    .clk     (clk),
    .clear_n (clear_n),
    .en      (en),
    .D       (D),
    .load    (load),
    .pgt_1Hz (pgt_1Hz),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .zero    (zero),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc ||
          {min_tens, min_ones, sec_tens, sec_ones} !== mon_e.dig ||
          zero !== (mon_e.dig == 16'h0000) || done !== mon_e.dn || state !== mon_e.st) begin
        errors++;
        $display("FAIL %s cyc=%0d: got %h%h:%h%h zero=%b done=%b state=%0d, want %h zero=%b done=%b state=%0d",
                 mon_e.name, cyc, min_tens, min_ones, sec_tens, sec_ones, zero, done, state,
                 mon_e.dig, (mon_e.dig == 16'h0000), mon_e.dn, mon_e.st);
      end
    end
  end

  task automatic drive(input logic cn, input logic e, input logic [3:0] d,
                       input logic ld, input logic p);
    @(posedge clk);
    #1;
    clear_n = cn; en = e; D = d; load = ld; pgt_1Hz = p;
  endtask

  task automatic expect_st(input string nm, input logic [15:0] dig,
                           input logic dn, input logic [1:0] st);
    exp_t x;
    x.cyc = cyc + 1; x.name = nm; x.dig = dig; x.dn = dn; x.st = st;
    sb.push_back(x);
  endtask

  task automatic rst();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_st("reset", 16'h0000, 1'b0, S_ENTRY);
  endtask

  task automatic press(input logic [3:0] d, input logic [15:0] dig);
    drive(1'b1, 1'b0, d, 1'b1, 1'b1);
    expect_st("key", dig, 1'b0, S_ENTRY);
    drive(1'b1, 1'b0, d, 1'b0, 1'b0);
    expect_st("key_rel", dig, 1'b0, S_ENTRY);
  endtask

  initial begin
    clear_n = 1'b0; en = 1'b0; D = 4'd0; load = 1'b0; pgt_1Hz = 1'b0;

    // Entry 1,3,0 then invalid digit and a load-less tick
    rst();
    press(4'd1, 16'h0001);
    press(4'd3, 16'h0013);
    press(4'd0, 16'h0130);
    press(4'd12, 16'h0130);
    drive(1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
    expect_st("tick_noload", 16'h0130, 1'b0, S_ENTRY);

    // Minute borrow and full countdown to DONE
    rst();
    press(4'd1, 16'h0001);
    press(4'd0, 16'h0010);
    press(4'd0, 16'h0100);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("go_count", 16'h0100, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("borrow", 16'h0059, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("borrow_lo", 16'h0059, 1'b0, S_COUNT);
    for (int k = 58; k >= 0; k--) begin
      drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      expect_st("cnt", {8'h00, 4'(k / 10), 4'(k % 10)}, (k == 0), (k == 0) ? S_DONE : S_COUNT);
      drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      expect_st("cnt_lo", {8'h00, 4'(k / 10), 4'(k % 10)}, 1'b0, (k == 0) ? S_DONE : S_COUNT);
    end
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("done_hold", 16'h0000, 1'b0, S_DONE);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_st("done_idle", 16'h0000, 1'b0, S_DONE);
    press(4'd7, 16'h0007);

    // Non-standard seconds
    rst();
    press(4'd0, 16'h0000);
    press(4'd0, 16'h0000);
    press(4'd9, 16'h0009);
    press(4'd9, 16'h0099);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("ns_go", 16'h0099, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("ns_dec", 16'h0098, 1'b0, S_COUNT);

    // Pause, resume, and simultaneous en/tick events
    rst();
    press(4'd4, 16'h0004);
    press(4'd5, 16'h0045);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("p_go", 16'h0045, 1'b0, S_COUNT);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_st("pause", 16'h0045, 1'b0, S_ENTRY);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("resume", 16'h0045, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("resume_dec", 16'h0044, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("resume_lo", 16'h0044, 1'b0, S_COUNT);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    expect_st("drop_on_tick", 16'h0043, 1'b0, S_ENTRY);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_st("drop_lo", 16'h0043, 1'b0, S_ENTRY);
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    expect_st("rise_on_tick", 16'h0043, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("rise_lo", 16'h0043, 1'b0, S_COUNT);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("rise_next", 16'h0042, 1'b0, S_COUNT);

    // Level pgt held high yields one decrement
    rst();
    press(4'd1, 16'h0001);
    press(4'd0, 16'h0010);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("lvl_go", 16'h0010, 1'b0, S_COUNT);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      expect_st("lvl_hold", 16'h0009, 1'b0, S_COUNT);
    end

    // Counting from 00:00 never leaves ENTRY
    rst();
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("zero_en", 16'h0000, 1'b0, S_ENTRY);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("zero_tick", 16'h0000, 1'b0, S_ENTRY);

    // Reset mid-count
    rst();
    press(4'd2, 16'h0002);
    press(4'd1, 16'h0021);
    press(4'd7, 16'h0217);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("r_go", 16'h0217, 1'b0, S_COUNT);
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_st("r_mid", 16'h0000, 1'b0, S_ENTRY);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_st("r_after", 16'h0000, 1'b0, S_ENTRY);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
